// File: rtl/add_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_sched_pkg
// Brief    : Shared types and constants for the add_sched scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package add_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

    // Signed saturation limits at the default operand width
    localparam logic [WIDTH_DEF-1:0] SMAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    localparam logic [WIDTH_DEF-1:0] SMIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/add_core.sv
`default_nettype none
// ============================================================================
// Module   : add_core
// Brief    : Combinational WIDTH-bit adder with unsigned carry and signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module add_core
    import add_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign sum    = w_full[WIDTH-1:0];
    assign carry  = w_full[WIDTH];
    // Like-signed operands producing a result of the other sign
    assign ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_full[WIDTH-1] != a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/add_sched.sv
`default_nettype none
// ============================================================================
// Module   : add_sched
// Brief    : Two-requester round-robin scheduler around a shared saturating adder.
// Revision : 1.0 - initial release
// ============================================================================
module add_sched
    import add_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_id,
    output logic             out_ovf,
    output logic             out_carry,
    output logic [7:0]       ovf_cnt
);

    localparam logic [WIDTH-1:0] c_smax = (WIDTH == WIDTH_DEF) ? WIDTH'(SMAX)
                                                               : {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin = (WIDTH == WIDTH_DEF) ? WIDTH'(SMIN)
                                                               : {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_next_state;

    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_sat;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_id;
    logic             r_out_ovf;
    logic             r_out_carry;
    logic [7:0]       r_ovf_cnt;

    logic             w_grant_id;
    logic             w_idle_ok;
    logic             w_accept;
    logic [WIDTH-1:0] w_core_sum;
    logic             w_core_carry;
    logic             w_core_ovf;
    logic [WIDTH-1:0] w_sat_sum;

    add_core #(
        .WIDTH (WIDTH)
    ) u_add_core (
        .a     (r_a),
        .b     (r_b),
        .sum   (w_core_sum),
        .carry (w_core_carry),
        .ovf   (w_core_ovf)
    );

    // Arbitration: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
        w_idle_ok  = (r_state == ST_IDLE) && !rst;
        req0_ready = w_idle_ok && req0_valid && !w_grant_id;
        req1_ready = w_idle_ok && req1_valid &&  w_grant_id;
        w_accept   = req0_ready || req1_ready;
    end

    always_comb begin
        w_sat_sum = w_core_sum;
        if (r_sat && w_core_ovf) begin
            w_sat_sum = r_a[WIDTH-1] ? c_smin : c_smax;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)  w_next_state = ST_EXEC;
            ST_EXEC:                  w_next_state = ST_RESULT;
            ST_RESULT: if (out_ready) w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= 1'b0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_id    <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_carry <= 1'b0;
            r_ovf_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a    <= w_grant_id ? req1_a : req0_a;
                        r_b    <= w_grant_id ? req1_b : req0_b;
                        r_id   <= w_grant_id;
                        r_sat  <= sat_en;
                        r_last <= w_grant_id;
                    end
                end
                ST_EXEC: begin
                    r_out_valid <= 1'b1;
                    r_out_sum   <= w_sat_sum;
                    r_out_id    <= r_id;
                    r_out_ovf   <= w_core_ovf;
                    r_out_carry <= w_core_carry;
                    if (w_core_ovf && (r_ovf_cnt != CNT_MAX)) begin
                        r_ovf_cnt <= r_ovf_cnt + 8'd1;
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_id    = r_out_id;
    assign out_ovf   = r_out_ovf;
    assign out_carry = r_out_carry;
    assign ovf_cnt   = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_sched
// Brief    : Self-checking bench for add_sched against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_add_sched;

    localparam int W    = 8;
    localparam int MAXP = 2**(W-1) - 1;
    localparam int MINN = -(2**(W-1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         sat_en = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_id, out_ovf, out_carry;
    logic [7:0]   ovf_cnt;

    add_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_id     (out_id),
        .out_ovf    (out_ovf),
        .out_carry  (out_carry),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired, got timeout expected event (cycle %0d)", name, cyc);
    endtask

    // Reference arithmetic in plain integers
    function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sat,
                                     output logic [W-1:0] sum, output bit ovf, output bit carry);
        int sa, sb, s, u;
        sa    = $signed(a);
        sb    = $signed(b);
        s     = sa + sb;
        u     = int'(a) + int'(b);
        ovf   = (s > MAXP) || (s < MINN);
        carry = (u >= 2**W);
        sum   = s[W-1:0];
        if (sat && ovf) sum = (s > 0) ? W'(MAXP) : W'(MINN);
    endfunction

    // Model state: op being computed, op being presented, fairness pointer
    bit           m_init = 0;
    bit           m_exec, m_present, m_last;
    int           m_cnt;
    logic [W-1:0] m_p_sum, m_sum;
    bit           m_p_ovf, m_p_carry, m_p_id, m_ovf, m_carry, m_id;

    int           res_count = 0;
    int           acc_cyc = 0, res_cyc = 0;
    logic [W-1:0] last_sum;
    logic         last_id, last_ovf, last_carry;
    bit           id_q[$];

    task automatic model_reset();
        m_exec    = 0;
        m_present = 0;
        m_last    = 1;
        m_cnt     = 0;
    endtask

    always @(negedge clk) begin
        bit has_win;
        bit win;
        cyc++;
        if (!m_init && rst) begin
            m_init = 1;
            model_reset();
        end
        if (m_init) begin
            has_win = 0;
            win     = 0;
            if (!rst && !m_exec && !m_present) begin
                if (req0_valid && req1_valid) begin
                    has_win = 1; win = !m_last;
                end else if (req0_valid) begin
                    has_win = 1; win = 0;
                end else if (req1_valid) begin
                    has_win = 1; win = 1;
                end
            end
            check("req0_ready", req0_ready, has_win && !win);
            check("req1_ready", req1_ready, has_win && win);
            check("ready_onehot", req0_ready && req1_ready, 0);
            check("out_valid", out_valid, m_present);
            if (m_present) begin
                check("out_sum", out_sum, m_sum);
                check("out_id", out_id, m_id);
                check("out_ovf", out_ovf, m_ovf);
                check("out_carry", out_carry, m_carry);
            end
            check("ovf_cnt", ovf_cnt, m_cnt);

            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc;
            if (out_valid === 1'b1 && out_ready) begin
                res_count++;
                res_cyc    = cyc;
                last_sum   = out_sum;
                last_id    = out_id;
                last_ovf   = out_ovf;
                last_carry = out_carry;
                id_q.push_back(out_id);
            end

            if (rst) begin
                model_reset();
            end else if (m_exec) begin
                m_exec    = 0;
                m_present = 1;
                m_sum     = m_p_sum;
                m_ovf     = m_p_ovf;
                m_carry   = m_p_carry;
                m_id      = m_p_id;
                if (m_p_ovf && m_cnt < 255) m_cnt++;
            end else if (m_present) begin
                if (out_ready) m_present = 0;
            end else if (has_win) begin
                if (win) model_op(req1_a, req1_b, sat_en, m_p_sum, m_p_ovf, m_p_carry);
                else     model_op(req0_a, req0_b, sat_en, m_p_sum, m_p_ovf, m_p_carry);
                m_p_id = win;
                m_last = win;
                m_exec = 1;
            end
        end
    end

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 8'h7F;
            1:       v = 8'h80;
            2:       v = 8'hFF;
            3:       v = 8'h01;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1; req0_valid = 0; req1_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic present(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit sat);
        sat_en = sat;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; end
    endtask

    task automatic wait_accept(input bit id, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin ok = 1; break; end
        end
        if (!ok) bound_expired("accept_wait");
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin seen = 1; break; end
        end
        if (!seen) bound_expired("out_valid_wait");
    endtask

    task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit sat);
        int n0;
        bit ok;
        n0 = res_count;
        @(posedge clk); #1;
        out_ready = 1;
        present(id, a, b, sat);
        wait_accept(id, ok);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_count != n0) break;
            @(posedge clk);
        end
        if (res_count == n0) bound_expired("result_wait");
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] s, input bit id,
                              input bit ovf, input bit carry);
        check({name, "_sum"},   last_sum,   s);
        check({name, "_id"},    last_id,    id);
        check({name, "_ovf"},   last_ovf,   ovf);
        check({name, "_carry"}, last_carry, carry);
    endtask

    initial begin
        bit ok;
        int n0;
        logic [W-1:0] held;

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_id",    out_id,    0);
        check("rst_out_ovf",   out_ovf,   0);
        check("rst_out_carry", out_carry, 0);
        check("rst_ovf_cnt",   ovf_cnt,   0);

        // Directed arithmetic cases with hand-computed results
        do_op(0, 8'h7F, 8'h01, 0);
        expect_res("p7f_p01", 8'h80, 0, 1, 0);
        check("latency", res_cyc - acc_cyc, 2);
        check("cnt_after_first", ovf_cnt, 1);
        do_op(1, 8'h80, 8'h80, 1);
        expect_res("n80_sat", 8'h80, 1, 1, 1);
        do_op(1, 8'h80, 8'h80, 0);
        expect_res("n80_wrap", 8'h00, 1, 1, 1);
        do_op(0, 8'hFF, 8'hFF, 0);
        expect_res("ff_ff", 8'hFE, 0, 0, 1);
        do_op(0, 8'h40, 8'h80, 0);
        expect_res("p40_n80", 8'hC0, 0, 0, 0);
        do_op(0, 8'h55, 8'h55, 1);
        expect_res("p55_sat", 8'h7F, 0, 1, 0);
        check("cnt_after_directed", ovf_cnt, 4);

        // Both requesters hammering: service alternates starting with 0
        reset_dut();
        id_q.delete();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 40 && id_q.size() < 4; i++) begin
            req0_a = rnd_op(); req0_b = rnd_op();
            req1_a = rnd_op(); req1_b = rnd_op();
            sat_en = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        check("rr_count", id_q.size() >= 4, 1);
        if (id_q.size() >= 4) begin
            check("rr_id0", id_q[0], 0);
            check("rr_id1", id_q[1], 1);
            check("rr_id2", id_q[2], 0);
            check("rr_id3", id_q[3], 1);
        end

        // Backpressure in RESULT while both requesters wait
        reset_dut();
        out_ready = 0;
        present(0, 8'h12, 8'h34, 0);
        wait_accept(0, ok);
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1;
        req1_a = 8'h01; req1_b = 8'h02;
        wait_out_valid();
        held = out_sum;
        check("stall_sum_value", held, 8'h46);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_sum", out_sum, 8'h46);
            check("stall_id", out_id, 0);
            check("stall_no_ready", req0_ready || req1_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin ok = 1; break; end
        end
        if (!ok) bound_expired("post_stall_grant");
        else     check("post_stall_grant_req1", req1_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (4) @(posedge clk);
        check("post_stall_id", last_id, 1);
        check("post_stall_sum", last_sum, 8'h03);

        // Reset while in EXEC
        reset_dut();
        present(0, 8'h7F, 8'h01, 0);
        wait_accept(0, ok);
        n0 = res_count;
        @(posedge clk); #1;
        req0_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_exec_valid", out_valid, 0);
        check("rst_exec_cnt", ovf_cnt, 0);
        repeat (5) @(negedge clk);
        check("rst_exec_no_result", res_count, n0);

        // Reset while in RESULT
        out_ready = 0;
        @(posedge clk); #1;
        present(1, 8'h7F, 8'h01, 0);
        wait_accept(1, ok);
        @(posedge clk); #1;
        req1_valid = 0;
        wait_out_valid();
        check("result_cnt_before_rst", ovf_cnt, 1);
        n0 = res_count;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        out_ready = 1;
        @(negedge clk);
        check("rst_result_valid", out_valid, 0);
        check("rst_result_cnt", ovf_cnt, 0);
        repeat (5) @(negedge clk);
        check("rst_result_no_result", res_count, n0);

        // Random traffic, backpressure and occasional resets
        reset_dut();
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = rnd_op(); req0_b = rnd_op();
            req1_a = rnd_op(); req1_b = rnd_op();
            sat_en    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk); #1;
        rst = 0; req0_valid = 0; req1_valid = 0; out_ready = 1;

        // Counter saturation
        reset_dut();
        for (int i = 0; i < 260; i++) begin
            do_op(1'(i % 2), 8'h7F, 8'h01, 0);
        end
        @(negedge clk);
        check("ovf_cnt_saturated", ovf_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  requester operand pair valid.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  signed two's-complement operands.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1 each  operand accepted this cycle.
REQ-007 SHALL have port sat_en  input  1  saturate on signed overflow, sampled at accept.
REQ-008 SHALL have ports out_valid  output  1, and out_ready  input  1  result handshake.
REQ-009 SHALL have ports out_sum  output  WIDTH, out_id  output  1, out_ovf  output  1, out_carry  output  1  result, requester index, signed overflow, unsigned carry-out.
REQ-010 SHALL have port ovf_cnt  output  8  saturating count of overflowed results.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, RESULT.
REQ-012 IDLE: req0_ready/req1_ready SHALL be combinational, at most one high, high only for the granted requester with valid high.
REQ-013 Grant SHALL be round-robin: single valid wins; both valid -> requester not granted last; after reset requester 0 has priority.
REQ-014 On handshake in IDLE, SHALL latch both operands, requester id and sat_en, update the last-grant pointer, go to EXEC.
REQ-015 EXEC: SHALL compute the WIDTH-bit sum and register out_sum/out_id/out_ovf/out_carry, assert out_valid, go to RESULT; no ready asserted.
REQ-016 out_ovf SHALL be 1 when both operands have equal sign bits differing from the raw sum sign bit; out_carry SHALL be bit WIDTH of the unsigned WIDTH+1 sum.
REQ-017 With latched sat_en=1 and out_ovf=1, out_sum SHALL be max positive (0x7F at WIDTH=8) for positive operands, min negative (0x80) for negative; otherwise the raw wrapped sum.
REQ-018 RESULT: outputs SHALL hold stable while out_ready=0; on out_valid&&out_ready SHALL clear out_valid and return to IDLE.
REQ-019 Latency SHALL be fixed: accept at edge k -> out_valid high after edge k+2; peak throughput one operation per 3 cycles with out_ready tied high.
REQ-020 No new request SHALL be accepted in EXEC or RESULT; requester valid held across those states is served in the next IDLE cycle.
REQ-021 ovf_cnt SHALL increment by 1 in the EXEC cycle that produces out_ovf=1 and SHALL saturate at 255 (no wrap).
REQ-022 Requester inputs changing while not granted SHALL have no effect.

Reset
REQ-023 On rst=1 at a clock edge: state IDLE, out_valid 0, out_sum 0, out_id 0, out_ovf 0, out_carry 0, ovf_cnt 0, last-grant pointer set so requester 0 wins next tie.
REQ-024 Reset SHALL take priority over any handshake in the same cycle; an in-flight operation (EXEC or RESULT) SHALL be discarded without a result.
REQ-025 During reset req0_ready and req1_ready SHALL be 0.

Structure
REQ-026 A shared package SHALL hold the FSM state enumeration, WIDTH default, and derived constants SMAX/SMIN (signed saturation limits).
REQ-027 The adder datapath SHALL be a sub-module add_core (inputs a, b; outputs sum, carry, ovf; purely combinational); saturation, arbitration and FSM SHALL live in add_sched.

Verification
REQ-028 Bench SHALL cover: req0 0x7F+0x01, sat_en=0 -> out_sum 0x80, ovf 1, carry 0, id 0, out_valid two edges after accept; ovf_cnt 1.
REQ-029 Bench SHALL cover: req1 0x80+0x80, sat_en=1 -> out_sum 0x80, ovf 1, carry 1, id 1; same with sat_en=0 -> out_sum 0x00.
REQ-030 Bench SHALL cover: 0xFF+0xFF -> out_sum 0xFE, ovf 0, carry 1; 0x40+0x80 -> 0xC0, ovf 0, carry 0; 0x55+0x55 with sat_en=1 -> 0x7F, ovf 1.
REQ-031 Bench SHALL cover: both requesters valid continuously, out_ready=1 -> out_id sequence 0,1,0,1; ready never high for both in one cycle.
REQ-032 Bench SHALL cover: out_ready=0 for 5 cycles in RESULT -> outputs stable, no ready asserted; after release, next grant follows round-robin.
REQ-033 Bench SHALL cover: rst asserted in EXEC and in RESULT -> next cycle out_valid 0, ovf_cnt 0, no result emitted; 260 overflowing ops -> ovf_cnt holds 255.
